msrv32_instr_queue: RTL
=======================

# msrv32_instr_queue

Parametrised instruction queue between fetch and decode. Buffers up to DEPTH fetched instructions with their PCs behind a valid/ready handshake, and splits the head entry into RV32 decode fields. A flush discards all entries, and the field outputs then present the canonical NOP. It is the buffered, multi-entry successor to the single-word flush/field-split mux feeding decode.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, 2..16.
- NOP_INSTR, 32'h00000013: word presented when flushing or empty (ADDI x0,x0,0).
- PC_W, 32: PC width.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- flush_in  input  1  discard all entries; present NOP.
- valid_in  input  1  fetch offers instr_in/pc_in.
- instr_in  input  32  fetched instruction.
- pc_in  input  PC_W  PC of instr_in.
- ready_out  output  1  queue can accept; equals (count_out != DEPTH).
- valid_out  output  1  head entry available to decode.
- ready_in  input  1  decode consumes head this cycle.
- opcode_out  output  7  head[6:0].
- funct3_out  output  3  head[14:12].
- funct7_out  output  7  head[31:25].
- rs1addr_out  output  5  head[19:15].
- rs2addr_out  output  5  head[24:20].
- rdaddr_out  output  5  head[11:7].
- csr_addr_out  output  12  head[31:20].
- instr_31_7_out  output  25  head[31:7].
- pc_out  output  PC_W  PC of head; 0 when the head word is NOP.
- count_out  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- Storage is a circular buffer of DEPTH {instr, pc} entries with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits wide and wrapping modulo DEPTH. Occupancy is held in count.
- push = valid_in & ready_out & ~flush_in.
- pop = valid_out & ready_in.
- valid_out = (count != 0) & ~flush_in.
- Head word = NOP_INSTR when flush_in or count == 0; otherwise mem[rd_ptr]. All field outputs are combinational slices of the head word.
- pc_out = 0 when the head word is NOP; otherwise the stored pc.
- Per-cycle update, in priority order:
  - rst_in: wr_ptr = rd_ptr = count = 0. Memory contents are don't-care.
  - Else flush_in: wr_ptr = rd_ptr = count = 0. Any simultaneous push or pop is ignored.
  - Else push only: write mem[wr_ptr]; wr_ptr+1; count+1.
  - Else pop only: rd_ptr+1; count-1.
  - Else push & pop: write mem[wr_ptr]; both pointers +1; count unchanged.
- Full (count == DEPTH): ready_out = 0, so no push is possible. A pop in the same cycle does not enable a push; ready_out has no combinational path from ready_in.
- Empty (count == 0): valid_out = 0. A same-cycle push is not bypassed; the new entry is visible the next cycle.
- Upstream contract: while valid_in = 1 and ready_out = 0, instr_in and pc_in hold. The queue does not check this.
- Order is strict FIFO. Entries are never reordered or duplicated.

## Timing
- Reset values: count_out 0, valid_out 0, ready_out 1, fields = NOP_INSTR slices (opcode 7'h13, others 0), pc_out 0.
- Latency: an entry pushed in cycle N is at the head in cycle N+1 if the queue was empty.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- flush_in acts combinationally on valid_out and the fields in the same cycle. The queue is empty from the next edge.
- Reset asserted mid-stream has the same effect as flush at the edge, and ready_out = 1 after the edge.
- No combinational paths:
  - from ready_in to ready_out;
  - from valid_in to valid_out.

## Test plan
- Reset, then idle: count_out = 0, valid_out = 0, ready_out = 1, opcode_out = 7'h13, rdaddr_out = 0, pc_out = 0.
- DEPTH = 4, push 0x00500093 (pc 0x0), 0x00A00113 (pc 0x4), 0x002081B3 (pc 0x8), 0x40310233 (pc 0xC) with ready_in = 0:
  - count_out = 4 and ready_out = 0 after the 4th push.
  - The head shows rdaddr_out = 1 and pc_out = 0.
  - A 5th valid_in is not accepted.
- Drain the full queue with ready_in = 1:
  - Heads appear in order with pc 0, 4, 8, C.
  - funct7_out = 7'h20 and rs2addr_out = 3 on the last entry.
  - valid_out = 0 after 4 pops.
- Hold count = 2 with push and pop together for 10 cycles: count_out stays 2, pointers wrap past DEPTH-1, and the output order matches the input order.
- flush_in while count = 3, with valid_in = 1 and ready_in = 1 in the same cycle:
  - That cycle: valid_out = 0 and opcode_out = 7'h13.
  - Next cycle: count_out = 0.
  - The flushed-cycle push is dropped.
- rst_in pulsed while count = 2: the next cycle shows count_out = 0, ready_out = 1 and NOP fields. A following push and pop pair returns the new word, not stale data.

Source files
------------

// File: rtl/msrv32_instr_queue.sv
// msrv32_instr_queue: DEPTH-entry fetch-to-decode FIFO with flush and RV32 field split of the head word
module msrv32_instr_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          PC_W      = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     flush_in,
  input  logic                     valid_in,
  input  logic [31:0]              instr_in,
  input  logic [PC_W-1:0]          pc_in,
  output logic                     ready_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [6:0]               opcode_out,
  output logic [2:0]               funct3_out,
  output logic [6:0]               funct7_out,
  output logic [4:0]               rs1addr_out,
  output logic [4:0]               rs2addr_out,
  output logic [4:0]               rdaddr_out,
  output logic [11:0]              csr_addr_out,
  output logic [24:0]              instr_31_7_out,
  output logic [PC_W-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]   count_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]     r_instr [DEPTH];
  logic [PC_W-1:0] r_pc [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push, w_pop, w_nop;
  logic [31:0]     w_head;
  // ready depends only on registered count, so there is no path from ready_in
  assign ready_out      = r_count != CW'(DEPTH);
  assign w_nop          = flush_in | (r_count == '0);
  assign valid_out      = ~w_nop;
  assign w_push         = valid_in & ready_out & ~flush_in;
  assign w_pop          = valid_out & ready_in;
  assign w_head         = w_nop ? NOP_INSTR : r_instr[r_rd_ptr];
  assign pc_out         = w_nop ? '0 : r_pc[r_rd_ptr];
  assign opcode_out     = w_head[6:0];
  assign funct3_out     = w_head[14:12];
  assign funct7_out     = w_head[31:25];
  assign rs1addr_out    = w_head[19:15];
  assign rs2addr_out    = w_head[24:20];
  assign rdaddr_out     = w_head[11:7];
  assign csr_addr_out   = w_head[31:20];
  assign instr_31_7_out = w_head[31:7];
  assign count_out      = r_count;
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= instr_in;
        r_pc[r_wr_ptr]    <= pc_in;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule
